fmap_pingpong_ram: RTL and testbench

- Parametrised, double-buffered (ping-pong) multi-channel feature-map store between a conv/pool producer layer and the next-layer consumer.
- Packs CH channels of DW-bit data per address; two banks of DEPTH words each.
- The producer fills one bank while the consumer reads the other.
- Bank ownership is handed over by a done/ready handshake.
- Memory is inferred RAM (no vendor IP). Read latency is 1 cycle with a valid strobe.

---
 rtl/fmap_pingpong_ram.sv | 142 ++++++++++++++
 tb/tb_fmap_pingpong_ram.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_pingpong_ram.sv
// Double-buffered multi-channel feature-map store: the producer fills one bank while the consumer drains the other.
// Optional sticky protocol-error flags are built only when FMAP_RAM_ERR_EN is defined.
module fmap_pingpong_ram #(
  parameter int CH    = 6,
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [CH*DW-1:0] wr_data,
  input  logic             wr_done,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [CH*DW-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_done,
  output logic             rd_ready,
  output logic [1:0]       err_flags
);

  localparam int WW = CH * DW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [WW-1:0] mem0 [DEPTH];
  logic [WW-1:0] mem1 [DEPTH];

  logic [1:0]    full_q, full_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [WW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic          wr_ready_s, rd_ready_s;
  logic          wr_acc_s, rd_acc_s;
  logic          wr_in_range_s, rd_in_range_s;
  logic [IW-1:0] wr_idx_s, rd_idx_s;
  logic [WW-1:0] rd_word_s;

  assign wr_ready_s    = ~full_q[wr_sel_q];
  assign rd_ready_s    = full_q[rd_sel_q];
  assign wr_acc_s      = wr_en & wr_ready_s;
  assign rd_acc_s      = rd_en & rd_ready_s;
  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_idx_s      = wr_addr[IW-1:0];
  assign rd_idx_s      = rd_addr[IW-1:0];
  assign rd_word_s     = rd_sel_q ? mem1[rd_idx_s] : mem0[rd_idx_s];

  // Bank ownership: done pulses only act when the side's current bank is in the expected state.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (wr_done && wr_ready_s) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end else begin
      wr_sel_d = wr_sel_q;
    end
    if (rd_done && rd_ready_s) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end else begin
      rd_sel_d = rd_sel_q;
    end
  end

  // Read port: out-of-range reads still complete, returning zero.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_acc_s) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_in_range_s ? rd_word_s : {WW{1'b0}};
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Handshake and read-output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= 2'b00;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_data_q  <= {WW{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // RAM write port, left unreset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_acc_s && wr_in_range_s) begin
      if (wr_sel_q) begin
        mem1[wr_idx_s] <= wr_data;
      end else begin
        mem0[wr_idx_s] <= wr_data;
      end
    end
  end

`ifdef FMAP_RAM_ERR_EN
  logic [1:0] err_q, err_d;

  // Sticky record of strobes issued against a bank that is not ready.
  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | ((wr_en | wr_done) & ~wr_ready_s);
    err_d[1] = err_q[1] | ((rd_en | rd_done) & ~rd_ready_s);
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = 2'b00;
`endif

  assign wr_ready = wr_ready_s;
  assign rd_ready = rd_ready_s;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_fmap_pingpong_ram.sv
// Self-checking bench for fmap_pingpong_ram: vector table, directed corner sequences and
// randomized traffic against a bank-ownership reference model.
module tb_fmap_pingpong_ram;

  localparam int CH = 6, DW = 16, DEPTH = 1024, AW = 11, WW = CH * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [WW-1:0] wr_data = '0;
  logic [WW-1:0] rd_data;
  logic          wr_ready, rd_ready, rd_valid;
  logic [1:0]    err_flags;

  fmap_pingpong_ram #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_done(rd_done), .rd_ready(rd_ready), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each bank is owned by whoever its full/empty flag says.
  logic [WW-1:0] m_mem [2][DEPTH];
  bit            m_known [2][DEPTH];
  bit            m_full [2];
  int            m_wsel, m_rsel;
  logic [WW-1:0] m_rd;
  bit            m_rd_known, m_rv;
  logic [1:0]    m_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pat(input logic [15:0] v);
    return {CH{v}};
  endfunction

  task automatic model_reset();
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_wsel = 0; m_rsel = 0;
    m_rd = '0; m_rd_known = 1'b1; m_rv = 1'b0; m_err = 2'b00;
  endtask

  task automatic model_edge();
    bit wr_rdy, rd_rdy;
    wr_rdy = !m_full[m_wsel];
    rd_rdy = m_full[m_rsel];
`ifdef FMAP_RAM_ERR_EN
    if ((wr_en || wr_done) && !wr_rdy) m_err[0] = 1'b1;
    if ((rd_en || rd_done) && !rd_rdy) m_err[1] = 1'b1;
`endif
    if (wr_en && wr_rdy && int'(wr_addr) < DEPTH) begin
      m_mem[m_wsel][int'(wr_addr)] = wr_data;
      m_known[m_wsel][int'(wr_addr)] = 1'b1;
    end
    m_rv = rd_en && rd_rdy;
    if (m_rv) begin
      if (int'(rd_addr) < DEPTH) begin
        m_rd = m_mem[m_rsel][int'(rd_addr)];
        m_rd_known = m_known[m_rsel][int'(rd_addr)];
      end else begin
        m_rd = '0;
        m_rd_known = 1'b1;
      end
    end
    if (wr_done && wr_rdy) begin m_full[m_wsel] = 1'b1; m_wsel = 1 - m_wsel; end
    if (rd_done && rd_rdy) begin m_full[m_rsel] = 1'b0; m_rsel = 1 - m_rsel; end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("wr_ready", 128'(wr_ready), 128'(!m_full[m_wsel]));
    chk("rd_ready", 128'(rd_ready), 128'(m_full[m_rsel]));
    chk("rd_valid", 128'(rd_valid), 128'(m_rv));
    chk("err_flags", 128'(err_flags), 128'(m_err));
    if (m_rd_known) chk("rd_data", 128'(rd_data), 128'(m_rd));
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_data", 128'(rd_data), 128'(0));
    chk("rst_wr_ready", 128'(wr_ready), 128'(1));
    chk("rst_rd_ready", 128'(rd_ready), 128'(0));
    chk("rst_err", 128'(err_flags), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          wr_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          e_wrdy, e_rrdy, e_rv;
    logic [WW-1:0] e_rd;
  } vec_t;

  vec_t          tbl [9];
  logic [WW-1:0] keep0, keep1023;
  logic [1:0]    exp_err;

  initial begin
    for (int k = 0; k < 4; k++)
      tbl[k] = '{1'b1, AW'(k), pat(16'h0100 + 16'(k)), 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, '0};
    tbl[4] = '{1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0};
    tbl[5] = '{1'b0, '0, '0, 1'b0, 1'b1, AW'(2), 1'b1, 1'b1, 1'b1, pat(16'h0102)};
    tbl[6] = '{1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, pat(16'h0102)};
    tbl[7] = '{1'b0, '0, '0, 1'b0, 1'b1, AW'(3), 1'b1, 1'b1, 1'b1, pat(16'h0103)};
    tbl[8] = '{1'b0, '0, '0, 1'b0, 1'b1, AW'(0), 1'b1, 1'b1, 1'b1, pat(16'h0100)};

    do_reset();

    // Bank0 fill, handover and first reads.
    for (int i = 0; i < 9; i++) begin
      wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
      wr_done = tbl[i].wr_done; rd_en = tbl[i].rd_en; rd_addr = tbl[i].rd_addr;
      tick();
      chk($sformatf("vec%0d_wr_ready", i), 128'(wr_ready), 128'(tbl[i].e_wrdy));
      chk($sformatf("vec%0d_rd_ready", i), 128'(rd_ready), 128'(tbl[i].e_rrdy));
      chk($sformatf("vec%0d_rd_valid", i), 128'(rd_valid), 128'(tbl[i].e_rv));
      chk($sformatf("vec%0d_rd_data", i), 128'(rd_data), 128'(tbl[i].e_rd));
      idle();
    end

    // Fill bank1; last write to addr 5 coincides with wr_done.
    for (int a = 0; a < DEPTH; a++) begin
      if (a == 5) continue;
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = {$urandom, $urandom, $urandom};
      if (a == 0) keep0 = wr_data;
      if (a == DEPTH - 1) keep1023 = wr_data;
      tick();
    end
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = pat(16'h0555); wr_done = 1'b1;
    tick();
    idle();
    tick();
    chk("both_full_wr_ready", 128'(wr_ready), 128'(0));
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = pat(16'hDEAD);
    tick();
    idle();
    rd_done = 1'b1;
    tick();
    idle();
    chk("release_wr_ready", 128'(wr_ready), 128'(1));
    chk("release_rd_ready", 128'(rd_ready), 128'(1));
    rd_en = 1'b1; rd_addr = AW'(0); tick();
    chk("dropped_write", 128'(rd_data), 128'(keep0));
    rd_addr = AW'(5); tick();
    chk("write_with_done", 128'(rd_data), 128'(pat(16'h0555)));
    rd_addr = AW'(1023); tick();
    chk("last_addr_valid", 128'(rd_valid), 128'(1));
    chk("last_addr_data", 128'(rd_data), 128'(keep1023));
    rd_addr = AW'(1024); tick();
    chk("oob_valid", 128'(rd_valid), 128'(1));
    chk("oob_data", 128'(rd_data), 128'(0));
    idle();

    // Refill bank0, release bank1, then swap both sides in one cycle.
    wr_en = 1'b1; wr_addr = AW'(9); wr_data = pat(16'h0909); wr_done = 1'b1;
    tick();
    idle();
    chk("refill_wr_ready", 128'(wr_ready), 128'(0));
    rd_done = 1'b1; tick(); idle();
    chk("b1_release_wr_ready", 128'(wr_ready), 128'(1));
    chk("b1_release_rd_ready", 128'(rd_ready), 128'(1));
    rd_en = 1'b1; rd_addr = AW'(9); wr_done = 1'b1; rd_done = 1'b1;
    tick();
    idle();
    chk("swap_old_bank_read", 128'(rd_data), 128'(pat(16'h0909)));
    chk("swap_wr_ready", 128'(wr_ready), 128'(1));
    chk("swap_rd_ready", 128'(rd_ready), 128'(1));
    rd_en = 1'b1; rd_addr = AW'(0); tick();
    chk("swap_rd_sel1", 128'(rd_data), 128'(keep0));

    // Reset while traffic is active.
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = pat(16'h0333);
    tick();
    do_reset();

    // Read with no full bank: dropped, and flagged when error logic is present.
    rd_en = 1'b1; rd_addr = AW'(0);
    tick();
    idle();
`ifdef FMAP_RAM_ERR_EN
    exp_err = 2'b10;
`else
    exp_err = 2'b00;
`endif
    chk("rd_err_valid", 128'(rd_valid), 128'(0));
    chk("rd_err_flags", 128'(err_flags), 128'(exp_err));
    repeat (3) tick();
    chk("rd_err_sticky", 128'(err_flags), 128'(exp_err));

    // Randomized producer/consumer traffic.
    for (int c = 0; c < 4000; c++) begin
      wr_en = ($urandom_range(0, 3) != 0);
      wr_addr = AW'($urandom_range(0, 1100));
      wr_data = {$urandom, $urandom, $urandom};
      wr_done = ($urandom_range(0, 40) == 0);
      rd_en = ($urandom_range(0, 2) != 0);
      rd_addr = AW'($urandom_range(0, 1100));
      rd_done = ($urandom_range(0, 40) == 0);
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
